// File: rtl/tbec_scrub_ctrl.sv
// ---------------------------------------------------------------------------
// tbec_scrub_ctrl
//   Sequencer in front of one tbec_full ECC memory. A single host port and a
//   background scrubber share the memory. The scrubber walks every word,
//   writes corrected data back when a single error is reported, and keeps
//   saturating counts of corrected and uncorrectable events.
//
// Optional feature macro: TBEC_HOST_CORRECT_EN
//   Defined   : a host read that sees mem_err=01 also writes the corrected
//               word back (extra H_WB state, ack one cycle later, corr_cnt+1).
//   Undefined : host reads never write; corr_cnt counts scrub events only.
//
// Host handshake: i_host_req is raised with we/addr/wdata stable and held
//   until o_host_ack (a one-cycle pulse). The request is accepted in an IDLE
//   cycle; the host drops req in the cycle after ack, and a req still high
//   in that cycle is a new request.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_host_req/we/addr/wdata  host request (sampled at accept)
//   o_host_ack            one-cycle completion pulse
//   o_host_rdata/err      read data and error code, held until next ack
//   i_scrub_en            enables the background scrubber
//   o_mem_addr/wdata/we   to tbec_full (tbec_addr, data_in, mem_we)
//   i_mem_rdata/err       from tbec_full (data_out, out_error_code)
//   o_corr_cnt/uncorr_cnt saturating event counters
//   o_scrub_ptr           next address to scrub
//   o_pass_done           pulse in the cycle after scrub_ptr wraps to 0
//   o_state               current FSM state (debug)
// ---------------------------------------------------------------------------
module tbec_scrub_ctrl #(
  parameter int DEPTH          = 8,
  parameter int ADDR_W         = 3,
  parameter int SCRUB_INTERVAL = 16,
  parameter int CNT_W          = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [15:0]       i_host_wdata,
  output logic              o_host_ack,
  output logic [15:0]       o_host_rdata,
  output logic [1:0]        o_host_err,
  input  logic              i_scrub_en,
  output logic [7:0]        o_mem_addr,
  output logic [15:0]       o_mem_wdata,
  output logic              o_mem_we,
  input  logic [15:0]       i_mem_rdata,
  input  logic [1:0]        i_mem_err,
  output logic [CNT_W-1:0]  o_corr_cnt,
  output logic [CNT_W-1:0]  o_uncorr_cnt,
  output logic [ADDR_W-1:0] o_scrub_ptr,
  output logic              o_pass_done,
  output logic [2:0]        o_state
);

  localparam int INT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [INT_W-1:0]  INT_MAX  = INT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_H_ACC  = 3'd1,
    ST_H_RESP = 3'd2,
    ST_S_RD   = 3'd3,
    ST_S_WB   = 3'd4,
    ST_H_WB   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_host_rdata;
  logic [1:0]          r_host_err;
  logic [15:0]         r_scrub_data;
  logic [INT_W-1:0]    r_int_cnt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]    r_corr;
  logic [CNT_W-1:0]    r_uncorr;
  logic                r_pass_done;

  logic [7:0]          w_mem_addr;
  logic [15:0]         w_mem_wdata;
  logic                w_mem_we;
  logic                w_ack;
  logic                w_adv;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; host wins over the scrubber in IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (i_host_req)                              w_next = ST_H_ACC;
        else if (r_int_cnt == INT_MAX && i_scrub_en) w_next = ST_S_RD;
      end
`ifdef TBEC_HOST_CORRECT_EN
      ST_H_ACC:  w_next = (!r_we && i_mem_err == 2'b01) ? ST_H_WB : ST_H_RESP;
`else
      ST_H_ACC:  w_next = ST_H_RESP;
`endif
      ST_H_WB:   w_next = ST_H_RESP;
      ST_H_RESP: w_next = ST_IDLE;
      ST_S_RD:   w_next = (i_mem_err == 2'b01) ? ST_S_WB : ST_IDLE;
      ST_S_WB:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Output decode from state and holding registers only
  always_comb begin
    w_mem_addr  = 8'd0;
    w_mem_wdata = 16'd0;
    w_mem_we    = 1'b0;
    w_ack       = 1'b0;
    unique case (r_state)
      ST_H_ACC: begin
        w_mem_addr  = 8'(r_addr);
        w_mem_wdata = r_wdata;
        w_mem_we    = r_we;
      end
      ST_H_WB: begin
        w_mem_addr  = 8'(r_addr);
        w_mem_wdata = r_host_rdata;
        w_mem_we    = 1'b1;
      end
      ST_H_RESP: w_ack = 1'b1;
      ST_S_RD:   w_mem_addr = 8'(r_ptr);
      ST_S_WB: begin
        w_mem_addr  = 8'(r_ptr);
        w_mem_wdata = r_scrub_data;
        w_mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  // The pointer moves when a scrub step finishes (clean/uncorrectable read
  // or after the write-back).
  assign w_adv = (r_state == ST_S_RD && i_mem_err != 2'b01) || (r_state == ST_S_WB);

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_host_rdata <= '0;
      r_host_err   <= '0;
      r_scrub_data <= '0;
      r_int_cnt    <= '0;
      r_ptr        <= '0;
      r_corr       <= '0;
      r_uncorr     <= '0;
      r_pass_done  <= 1'b0;
    end else begin
      r_pass_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_host_req) begin
            r_we    <= i_host_we;
            r_addr  <= i_host_addr;
            r_wdata <= i_host_wdata;
          end else if (r_int_cnt == INT_MAX) begin
            // Saturates while scrubbing is disabled so a step starts as
            // soon as it is re-enabled.
            if (i_scrub_en) r_int_cnt <= '0;
          end else begin
            r_int_cnt <= r_int_cnt + INT_W'(1);
          end
        end
        ST_H_ACC: begin
          if (!r_we) begin
            r_host_rdata <= i_mem_rdata;
            r_host_err   <= i_mem_err;
          end else begin
            r_host_err   <= 2'b00;
          end
        end
        ST_H_WB: begin
          if (r_corr != CNT_MAX) r_corr <= r_corr + CNT_W'(1);
        end
        ST_S_RD: begin
          r_scrub_data <= i_mem_rdata;
          if (i_mem_err == 2'b01) begin
            if (r_corr != CNT_MAX) r_corr <= r_corr + CNT_W'(1);
          end else if (i_mem_err[1]) begin
            if (r_uncorr != CNT_MAX) r_uncorr <= r_uncorr + CNT_W'(1);
          end
        end
        default: ;
      endcase
      if (w_adv) begin
        r_ptr       <= (r_ptr == PTR_LAST) ? '0 : r_ptr + ADDR_W'(1);
        r_pass_done <= (r_ptr == PTR_LAST);
      end
    end
  end

  // Reset aborts an in-flight access: no write strobe, no ack.
  assign o_mem_we     = w_mem_we & ~i_rst;
  assign o_host_ack   = w_ack & ~i_rst;
  assign o_mem_addr   = w_mem_addr;
  assign o_mem_wdata  = w_mem_wdata;
  assign o_host_rdata = r_host_rdata;
  assign o_host_err   = r_host_err;
  assign o_corr_cnt   = r_corr;
  assign o_uncorr_cnt = r_uncorr;
  assign o_scrub_ptr  = r_ptr;
  assign o_pass_done  = r_pass_done;
  assign o_state      = r_state;

endmodule

// File: tb/tb_tbec_scrub_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tbec_scrub_ctrl
//   Bench for tbec_scrub_ctrl. A behavioural stand-in for the tbec_full
//   memory keeps a data word and an injected error code per address. The
//   reference model tracks memory contents, faults, scrub pointer and counter
//   values; expected host responses and expected memory writes are queued at
//   issue time and popped by an independent monitor.
// ---------------------------------------------------------------------------
module tb_tbec_scrub_ctrl;

  localparam int CNT_W = 2;   // small counters so saturation is reachable
  localparam logic [CNT_W-1:0] CMAX = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             host_req = 1'b0, host_we = 1'b0, scrub_en = 1'b0;
  logic [2:0]       host_addr = '0;
  logic [15:0]      host_wdata = '0;
  logic             host_ack, mem_we, pass_done;
  logic [15:0]      host_rdata, mem_wdata, mem_rdata;
  logic [1:0]       host_err, mem_err;
  logic [7:0]       mem_addr;
  logic [CNT_W-1:0] corr_cnt, uncorr_cnt;
  logic [2:0]       scrub_ptr, dut_state;

  tbec_scrub_ctrl #(.DEPTH(8), .ADDR_W(3), .SCRUB_INTERVAL(16), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
    .i_host_wdata(host_wdata), .o_host_ack(host_ack), .o_host_rdata(host_rdata),
    .o_host_err(host_err), .i_scrub_en(scrub_en),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_we(mem_we),
    .i_mem_rdata(mem_rdata), .i_mem_err(mem_err),
    .o_corr_cnt(corr_cnt), .o_uncorr_cnt(uncorr_cnt), .o_scrub_ptr(scrub_ptr),
    .o_pass_done(pass_done), .o_state(dut_state)
  );

  // ---------------- memory stand-in ----------------
  function automatic logic [15:0] init_word(input int i);
    return 16'h3C5A ^ 16'(i * 16'h1111);
  endfunction

  logic [15:0] mem_data [8];
  logic [1:0]  mem_fault [8];
  bit          mem_inited = 1'b0;
  int          inj_seq = 0, inj_done = 0;
  logic [2:0]  inj_a = '0;
  logic [1:0]  inj_f = '0;

  // A reported uncorrectable word comes back corrupted; a single error
  // comes back corrected.
  assign mem_rdata = mem_fault[mem_addr[2:0]][1] ? (mem_data[mem_addr[2:0]] ^ 16'h0003)
                                                 : mem_data[mem_addr[2:0]];
  assign mem_err   = mem_fault[mem_addr[2:0]];

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 8; i++) begin
        mem_data[i]  = init_word(i);
        mem_fault[i] = 2'b00;
      end
      mem_inited = 1'b1;
    end
    if (mem_we) begin
      mem_data[mem_addr[2:0]]  = mem_wdata;
      mem_fault[mem_addr[2:0]] = 2'b00;   // encoder re-encodes a clean word
    end
    if (inj_seq != inj_done) begin
      mem_fault[inj_a] = inj_f;
      inj_done = inj_seq;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [15:0]      ref_data [8];
  logic [1:0]       ref_fault [8];
  int               ref_ptr = 0;
  logic [CNT_W-1:0] ref_corr = '0, ref_uncorr = '0;
  int               exp_pass = 0, pass_seen = 0;
  logic [18:0]      hq [$];   // {is_read, err[1:0], rdata[15:0]}
  logic [18:0]      wq [$];   // {addr[2:0], data[15:0]}
  int               n_checks = 0, n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CMAX) ? v : v + CNT_W'(1);
  endfunction

  // One scrub step on the reference model
  task automatic model_step();
    if (ref_fault[ref_ptr] == 2'b01) begin
      wq.push_back({3'(ref_ptr), ref_data[ref_ptr]});
      ref_fault[ref_ptr] = 2'b00;
      ref_corr = sat_inc(ref_corr);
    end else if (ref_fault[ref_ptr] != 2'b00) begin
      ref_uncorr = sat_inc(ref_uncorr);
    end
    ref_ptr = (ref_ptr + 1) % 8;
    if (ref_ptr == 0) exp_pass++;
  endtask

  // ---------------- monitor ----------------
  logic [18:0] mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      if (host_ack) begin
        if (hq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_ack: got ack with nothing pending, required no ack");
        end else begin
          mon_e = hq.pop_front();
          check("host_err", 32'(host_err), 32'(mon_e[17:16]));
          if (mon_e[18]) check("host_rdata", 32'(host_rdata), 32'(mon_e[15:0]));
        end
      end
      if (mem_we) begin
        if (wq.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_write: got write addr %0h data %0h, required none",
                   mem_addr, mem_wdata);
        end else begin
          mon_e = wq.pop_front();
          check("write_addr", 32'(mem_addr), 32'(mon_e[18:16]));
          check("write_data", 32'(mem_wdata), 32'(mon_e[15:0]));
        end
      end
      if (pass_done) begin
        pass_seen++;
        check("pass_done_ptr", 32'(scrub_ptr), 32'd0);
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic inject(input int a, input logic [1:0] f);
    ref_fault[a] = f;
    inj_a = 3'(a);
    inj_f = f;
    inj_seq++;
    @(negedge clk);
  endtask

  // extra: cycles the request is expected to wait behind a scrub step
  task automatic host_op(input bit we, input int a, input logic [15:0] d, input int extra);
    int lat, exp_lat;
    exp_lat = 2 + extra;
    if (we) begin
      wq.push_back({3'(a), d});
      hq.push_back({1'b0, 2'b00, 16'h0000});
      ref_data[a]  = d;
      ref_fault[a] = 2'b00;
    end else begin
      hq.push_back({1'b1, ref_fault[a],
                    ref_fault[a][1] ? (ref_data[a] ^ 16'h0003) : ref_data[a]});
`ifdef TBEC_HOST_CORRECT_EN
      if (ref_fault[a] == 2'b01) begin
        wq.push_back({3'(a), ref_data[a]});
        ref_fault[a] = 2'b00;
        ref_corr = sat_inc(ref_corr);
        exp_lat++;
      end
`endif
    end
    host_req = 1'b1; host_we = we; host_addr = 3'(a); host_wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!host_ack && lat < 20);
    host_req = 1'b0;
    check("ack_latency", 32'(lat), 32'(exp_lat));
    @(negedge clk);
  endtask

  // Run n scrub steps; the model predicts their writes and counts.
  task automatic scrub_steps(input int n, input bit keep_en);
    int done, budget;
    logic [2:0] last;
    for (int k = 0; k < n; k++) model_step();
    scrub_en = 1'b1;
    done = 0; budget = 0; last = scrub_ptr;
    while (done < n && budget < n * 20 + 20) begin
      @(negedge clk);
      budget++;
      if (scrub_ptr != last) begin
        done++;
        last = scrub_ptr;
      end
    end
    if (done < n) begin
      n_checks++; n_err++;
      $display("FAIL scrub_timeout: got %0d steps, required %0d", done, n);
    end
    if (!keep_en) scrub_en = 1'b0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_corr"},   32'(corr_cnt),   32'(ref_corr));
    check({tag, "_uncorr"}, 32'(uncorr_cnt), 32'(ref_uncorr));
    check({tag, "_ptr"},    32'(scrub_ptr),  32'(ref_ptr));
    check({tag, "_passes"}, 32'(pass_seen),  32'(exp_pass));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, a;
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      ref_data[i]  = init_word(i);
      ref_fault[i] = 2'b00;
    end

    // Reset with scrubbing already enabled
    scrub_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(host_ack), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_rdata", 32'(host_rdata), 0);
    check("rst_err", 32'(host_err), 0);
    check("rst_corr", 32'(corr_cnt), 0);
    check("rst_uncorr", 32'(uncorr_cnt), 0);
    check("rst_ptr", 32'(scrub_ptr), 0);
    check("rst_pass", 32'(pass_done), 0);
    check("rst_state", 32'(dut_state), 0);

    // First scrub step finishes on the 17th edge after release
    // (16 idle cycles then one read cycle), then the rest of the pass.
    rst = 1'b0;
    model_step();
    n = 0;
    while (scrub_ptr == 3'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("first_step_cycle", 32'(n), 32'd17);
    scrub_steps(7, 1'b0);
    @(negedge clk);
    check_counters("clean_pass");

    // Directed host write then read
    host_op(1'b1, 3, 16'hA5A5, 0);
    host_op(1'b0, 3, 16'h0000, 0);

    // Random host traffic with fault injection, scrubber idle
    for (int i = 0; i < 24; i++) begin
      a = $urandom_range(0, 7);
      n = $urandom_range(0, 9);
      if (n < 2)      inject(a, 2'($urandom_range(1, 3)));
      else if (n < 6) host_op(1'b1, a, 16'($urandom), 0);
      else            host_op(1'b0, a, 16'h0000, 0);
    end

    // Single error in word 5, double error in word 2; one pass then more
    // passes so the uncorrectable counter saturates.
    inject(5, 2'b01);
    inject(2, 2'b10);
    d = ref_data[2];
    scrub_steps(8, 1'b0);
    @(negedge clk);
    check_counters("fault_pass");
    check("word5_fault_cleared", 32'(mem_fault[5]), 0);
    check("word2_untouched", 32'(mem_data[2]), 32'(d));
    check("word2_still_bad", 32'(mem_fault[2]), 32'(2'b10));
    scrub_steps(24, 1'b0);
    @(negedge clk);
    check_counters("sat_pass");

    // Host request raised in the cycle a scrub step with write-back begins
    scrub_steps(1, 1'b1);
    a = ref_ptr;
    inject(a, 2'b01);
    model_step();
    repeat (15) @(negedge clk);
    host_op(1'b1, $urandom_range(0, 7), 16'($urandom), 2);
    scrub_en = 1'b0;
    @(negedge clk);
    check_counters("collide");

    // Reset during H_ACC of a write to address 1
    d = ~ref_data[1];
    wq.push_back({3'd1, d});   // strobe is visible during H_ACC but must not commit
    host_req = 1'b1; host_we = 1'b1; host_addr = 3'd1; host_wdata = d;
    @(negedge clk);
    check("hacc_we", 32'(mem_we), 1);
    check("hacc_addr", 32'(mem_addr), 1);
    #2;
    rst = 1'b1;
    host_req = 1'b0;
    ref_ptr = 0; ref_corr = '0; ref_uncorr = '0;
    @(negedge clk);
    check("abort_ack", 32'(host_ack), 0);
    check("abort_we", 32'(mem_we), 0);
    check("abort_state", 32'(dut_state), 0);
    check("abort_corr", 32'(corr_cnt), 0);
    check("abort_uncorr", 32'(uncorr_cnt), 0);
    check("abort_ptr", 32'(scrub_ptr), 0);
    check("abort_word1", 32'(mem_data[1]), 32'(ref_data[1]));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_abort_word1", 32'(mem_data[1]), 32'(ref_data[1]));
    check("post_abort_state", 32'(dut_state), 0);

    check("host_queue_empty", 32'(hq.size()), 0);
    check("write_queue_empty", 32'(wq.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    n_checks++; n_err++;
    $display("FAIL global_timeout: got no completion, required finish");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/tbec_scrub_ctrl.md
Name: tbec_scrub_ctrl

Overview:
- Sequencer in front of one tbec_full instance: drives its tbec_addr, data_in and mem_we, and observes data_out and out_error_code.
- Shares the ECC memory between a single host port and a background scrubber.
- The scrubber walks all words, writes back corrected data on single-error detection, and counts corrected and uncorrectable events.

Parameters:
DEPTH, 8, number of ECC words (matches the tbec_full array)
ADDR_W, 3, host/scrub address width; mem_addr upper bits are zero
SCRUB_INTERVAL, 16, idle cycles between scrub steps (>=1)
CNT_W, 16, width of the saturating error counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
host_req  in  1  request; held high until host_ack
host_we  in  1  1=write, 0=read; sampled at accept
host_addr  in  ADDR_W  word address; sampled at accept
host_wdata  in  16  write data; sampled at accept
host_ack  out  1  one-cycle completion pulse
host_rdata  out  16  decoded read data; valid with host_ack, held until next ack
host_err  out  2  error code of the read; 00 for writes
scrub_en  in  1  enables the background scrub
mem_addr  out  8  to tbec_addr
mem_wdata  out  16  to data_in
mem_we  out  1  to mem_we
mem_rdata  in  16  from data_out
mem_err  in  2  from out_error_code: 00 clean, 01 corrected, 10 uncorrectable, 11 treated as uncorrectable
corr_cnt  out  CNT_W  scrub corrections, saturating
uncorr_cnt  out  CNT_W  scrub uncorrectable detections, saturating
scrub_ptr  out  ADDR_W  next address to scrub
pass_done  out  1  one-cycle pulse when scrub_ptr wraps from DEPTH-1 to 0

Behaviour:
- Reset: state IDLE; all outputs 0 (mem_we=0, host_ack=0, counters 0, scrub_ptr 0); interval counter 0. Reset during any state aborts the access: no ack, no write-back.
- Memory reads are combinational; a write commits on the clk edge with mem_we=1. mem_* outputs come only from the state and holding registers, with no combinational path from host_* inputs.
- FSM states: IDLE, H_ACC, H_RESP, S_RD, S_WB.
- IDLE, host_req=1:
  - Latch we/addr/wdata and go to H_ACC.
  - Host has priority over the scrubber.
  - Interval counter holds.
- IDLE, host_req=0: interval counter increments.
  - At SCRUB_INTERVAL-1 with scrub_en=1: clear the counter, go to S_RD.
  - With scrub_en=0: the counter saturates at SCRUB_INTERVAL-1.
- H_ACC:
  - mem_addr=latched addr; mem_we=latched we; mem_wdata=latched wdata.
  - On reads, capture mem_rdata/mem_err into host_rdata/host_err. Writes set host_err=00.
  - Go to H_RESP.
- H_RESP: host_ack=1; go to IDLE.
  - Host drops req the cycle after ack; a req still high in that cycle is a new request.
  - Host latency from accept: write commits at end of H_ACC; ack 2 cycles after accept.
- S_RD: mem_addr=scrub_ptr, mem_we=0; capture mem_rdata.
  - mem_err=01: corr_cnt+1, go to S_WB.
  - mem_err=1x: uncorr_cnt+1, no write-back, go to IDLE, advance ptr.
  - mem_err=00: go to IDLE, advance ptr.
- S_WB: mem_addr=scrub_ptr, mem_wdata=captured word, mem_we=1 (the encoder re-encodes it); go to IDLE and advance ptr.
- A scrub step (S_RD→S_WB) is atomic. A host_req arriving mid-step waits in IDLE, worst-case 2 extra cycles.
- Pointer advance: scrub_ptr wraps DEPTH-1→0, with a pass_done pulse in the cycle after the wrap edge.
- Counters saturate at all-ones; they clear only on reset.
- Deasserting scrub_en mid-step lets the step complete; no new step starts.

Optional Feature:
TBEC_HOST_CORRECT_EN
- Defined: a host read returning mem_err=01 inserts state H_WB after H_ACC. H_WB writes the corrected word back to the host address (mem_we=1), increments corr_cnt, then goes to H_RESP. Ack latency becomes 3 cycles for that read only.
- Undefined: host reads never write; corr_cnt counts scrub events only.

Test Plan:
- Reset then host write addr 3 data 16'hA5A5, then read addr 3 → ack 2 cycles after each accept; host_rdata=16'hA5A5, host_err=00; mem_we high exactly one cycle.
- scrub_en=1, no host traffic, SCRUB_INTERVAL=16 → first S_RD at cycle 16 after reset release; scrub_ptr 0→7→0 with a pass_done pulse after 8 steps; mem_we never asserts on a clean memory.
- Force one bit flip in word 5 (bench deposit into the tbec_full array) → scrub reaches 5: corr_cnt=1, write-back cycle with mem_wdata=original data; next pass reads err 00.
- Force a double flip in word 2 → uncorr_cnt=1, no mem_we for addr 2, word left unchanged.
- host_req asserted in the same cycle S_RD begins → S_RD/S_WB complete first; host accept in the following IDLE; ack ≤4 cycles after req.
- rst pulsed during H_ACC of a write to addr 1 → no host_ack; all outputs 0 next cycle; state IDLE.
